// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter/sequencer.
// Widths are fixed: 8-bit data, 3-bit op, 4-bit {C,N,O,Z} flags.
package alu_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;
    localparam int FLAG_W = 4;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_NOT = 3'b100,
        OP_CMP = 3'b101,
        OP_SHR = 3'b110,
        OP_SHL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle: request/operand inputs, grant/done pulses and the
// captured result. master = requesters, slave = arbiter.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic              req0, req1;
    logic [OP_W-1:0]   op0, op1;
    logic [DATA_W-1:0] a0, b0, a1, b1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic              busy;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, result, flags, busy
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, result, flags, busy
    );
endinterface

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin pick. On contention the requester that
// was not granted last wins.
module rr_arbiter_2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);
    assign valid  = req0 | req1;
    assign winner = (req0 && req1) ? ~last : req1;
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered 8-bit ALU between two requesters: arbitrate in IDLE,
// hold ALU inputs through ISSUE and CAPTURE, then return result with a done pulse.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_en_out,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flags
);
    state_e   state;
    logic     last;
    logic     owner;
    logic     win;
    logic     win_vld;
    alu_req_t pick;

    rr_arbiter_2 u_rr (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last),
        .winner (win),
        .valid  (win_vld)
    );

    always_comb begin
        pick = '{op: bus.op0, a: bus.a0, b: bus.b0};
        if (win) pick = '{op: bus.op1, a: bus.a1, b: bus.b1};
    end

    // alu_op/a/b double as the operand latches, so they hold in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last       <= 1'b1;
            owner      <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_en_out <= 1'b0;
            bus.gnt0   <= 1'b0;
            bus.gnt1   <= 1'b0;
            bus.done0  <= 1'b0;
            bus.done1  <= 1'b0;
            bus.result <= '0;
            bus.flags  <= '0;
            bus.busy   <= 1'b0;
        end else begin
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state    <= ST_ISSUE;
                        owner    <= win;
                        last     <= win;
                        alu_op   <= pick.op;
                        alu_a    <= pick.a;
                        alu_b    <= pick.b;
                        bus.gnt0 <= ~win;
                        bus.gnt1 <= win;
                        bus.busy <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state      <= ST_CAPTURE;
                    alu_en_out <= 1'b1;
                end
                ST_CAPTURE: begin
                    state      <= ST_IDLE;
                    alu_en_out <= 1'b0;
                    bus.busy   <= 1'b0;
                    bus.result <= alu_out;
                    bus.flags  <= alu_flags;
                    bus.done0  <= ~owner;
                    bus.done1  <= owner;
                end
                default: begin
                    state      <= ST_IDLE;
                    alu_en_out <= 1'b0;
                    bus.busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule
